// File: rtl/loop_branch_resolver.sv
// Branch resolver for the fetch/loop-replay path: keeps predictions in order and redirects on a mispredict.
// Optional statistics outputs are enabled by defining LOOP_BRANCH_RESOLVER_STATS_EN.
module loop_branch_resolver #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pred_valid,
   input  logic [DATA_W-1:0] pred_pc,
   input  logic              pred_taken,
   input  logic [DATA_W-1:0] pred_target,
   output logic              pred_ready,
   input  logic              resolve_valid,
   input  logic [DATA_W-1:0] resolve_pc,
   input  logic              resolve_taken,
   input  logic [DATA_W-1:0] resolve_target,
   output logic              mispredict,
   output logic [DATA_W-1:0] correct_pc,
   output logic              order_err,
   output logic [2:0]        pending
`ifdef LOOP_BRANCH_RESOLVER_STATS_EN
   ,
   output logic [15:0]       resolve_count,
   output logic [15:0]       mispredict_count
`endif
);

   localparam int DEPTH = 4;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] TRACK   = 2'd1;
   localparam logic [1:0] RECOVER = 2'd2;

   logic [1:0]        state;
   logic              rec_cnt;
   logic [1:0]        head;
   logic [1:0]        tail;
   logic [2:0]        count;

   logic [DATA_W-1:0] q_pc     [DEPTH];
   logic              q_taken  [DEPTH];
   logic [DATA_W-1:0] q_target [DEPTH];

   logic              push_p0;
   logic              res_p0;
   logic              hit_p0;
   logic              oerr_p0;
   logic              mis_p0;
   logic [DATA_W-1:0] fix_pc_p0;
   logic [2:0]        count_nxt;

   // ---- stage p0: accept, head compare, mispredict decision ----
   always_comb begin
      pred_ready = (count < 3'd4) && (state != RECOVER);
      push_p0    = pred_valid && pred_ready;
      res_p0     = resolve_valid && (state != RECOVER);
      hit_p0     = res_p0 && (count != 3'd0) && (resolve_pc == q_pc[head]);
      oerr_p0    = res_p0 && !hit_p0;
      // When both sides say not-taken the targets are meaningless and are not compared.
      mis_p0     = hit_p0 && ((q_taken[head] != resolve_taken) ||
                              (resolve_taken && (q_target[head] != resolve_target)));
      fix_pc_p0  = resolve_taken ? resolve_target : (resolve_pc + DATA_W'(4));
      count_nxt  = count + {2'b00, push_p0} - {2'b00, hit_p0};
   end

   // ---- stage p1: queue control, state and registered pulses ----
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rec_cnt    <= 1'b0;
         head       <= 2'd0;
         tail       <= 2'd0;
         count      <= 3'd0;
         mispredict <= 1'b0;
         order_err  <= 1'b0;
         correct_pc <= '0;
      end else begin
         mispredict <= mis_p0;
         order_err  <= oerr_p0;
         correct_pc <= mis_p0 ? fix_pc_p0 : '0;
         if (mis_p0) begin
            head    <= 2'd0;
            tail    <= 2'd0;
            count   <= 3'd0;
            state   <= RECOVER;
            rec_cnt <= 1'b0;
         end else begin
            if (push_p0) tail <= tail + 2'd1;
            if (hit_p0)  head <= head + 2'd1;
            count <= count_nxt;
            if (state == RECOVER) begin
               rec_cnt <= ~rec_cnt;
               if (rec_cnt) state <= IDLE;
            end else begin
               state <= (count_nxt == 3'd0) ? IDLE : TRACK;
            end
         end
      end
   end

   // Entry storage carries no reset; occupancy is tracked solely by count/head/tail.
   always_ff @(posedge clk) begin
      if (push_p0 && !mis_p0) begin
         q_pc[tail]     <= pred_pc;
         q_taken[tail]  <= pred_taken;
         q_target[tail] <= pred_target;
      end
   end

   assign pending = count;

`ifdef LOOP_BRANCH_RESOLVER_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         resolve_count    <= 16'd0;
         mispredict_count <= 16'd0;
      end else begin
         if (hit_p0 && (resolve_count != 16'hFFFF))
            resolve_count <= resolve_count + 16'd1;
         if (mis_p0 && (mispredict_count != 16'hFFFF))
            mispredict_count <= mispredict_count + 16'd1;
      end
   end
`endif

endmodule

// File: doc/loop_branch_resolver.md
LOOP_BRANCH_RESOLVER -- requirements
Module: loop_branch_resolver

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port pred_valid, input, 1 bit: the fetch/loop-replay side offers a predicted branch.
REQ-005 The block SHALL have port pred_pc, input, 32 bits: PC of the predicted branch.
REQ-006 The block SHALL have port pred_taken, input, 1 bit: predicted direction.
REQ-007 The block SHALL have port pred_target, input, 32 bits: predicted target, meaningful only when pred_taken=1.
REQ-008 The block SHALL have port pred_ready, output, 1 bit: prediction accepted this cycle if pred_valid=1.
REQ-009 The block SHALL have port resolve_valid, input, 1 bit: execute stage reports a resolved branch.
REQ-010 The block SHALL have port resolve_pc, input, 32 bits: PC of the resolved branch.
REQ-011 The block SHALL have port resolve_taken, input, 1 bit: actual direction.
REQ-012 The block SHALL have port resolve_target, input, 32 bits: actual taken target.
REQ-013 The block SHALL have port mispredict, output, 1 bit: single-cycle pulse to the fetch/loop FSM.
REQ-014 The block SHALL have port correct_pc, output, 32 bits: redirect PC; valid while mispredict=1.
REQ-015 The block SHALL have port order_err, output, 1 bit: single-cycle pulse on a resolve with no matching queue head.
REQ-016 The block SHALL have port pending, output, 3 bits: outstanding predictions, range 0..4.

Function
REQ-017 The block SHALL hold outstanding predictions in a 4-entry in-order queue of {pc, taken, target}.
REQ-018 The block SHALL implement states IDLE (queue empty), TRACK (queue non-empty) and RECOVER (2-cycle flush window).
REQ-019 The block SHALL drive pred_ready = (pending<4) and (state!=RECOVER); a push occurs on pred_valid and pred_ready.
REQ-020 The block SHALL NOT allow a push into a full queue, even in a cycle in which a pop also occurs.
REQ-021 The block SHALL, on a push and a pop in the same cycle, perform both and leave pending unchanged.
REQ-022 The block SHALL ignore resolve_valid while in RECOVER.
REQ-023 The block SHALL, on resolve_valid with an empty queue, or with resolve_pc != head pc, pulse order_err in the next cycle, leave the queue untouched and leave the state unchanged.
REQ-024 The block SHALL, when resolve_pc matches the head, pop the head.
REQ-025 A popped entry SHALL be a mispredict when taken differs, or when both are taken and the targets differ.
REQ-026 The block SHALL, on a mispredict, register mispredict=1 in the following cycle, with correct_pc = resolve_target if resolve_taken=1, else resolve_pc+4 (32-bit wrap).
REQ-027 The block SHALL, on a mispredict, clear the whole queue (pending=0 next cycle), discard any same-cycle push, and enter RECOVER.
REQ-028 The block SHALL leave RECOVER after exactly 2 cycles and enter IDLE.
REQ-029 The block SHALL, on a correct prediction, move to IDLE if the queue becomes empty; otherwise it remains in TRACK.
REQ-030 The block SHALL drive correct_pc to 0 whenever mispredict=0.

Reset
REQ-031 The block SHALL, when reset=1 at a rising edge: enter IDLE, clear the queue, set pending=0, mispredict=0, order_err=0, correct_pc=0, pred_ready=1 in the next cycle.
REQ-032 The block SHALL, on a reset in any state including RECOVER, abort the in-progress operation, and reset SHALL take precedence over a same-cycle push or resolve.

Configuration
REQ-033 With macro LOOP_BRANCH_RESOLVER_STATS_EN defined, the block SHALL add 16-bit outputs resolve_count and mispredict_count.
REQ-034 With LOOP_BRANCH_RESOLVER_STATS_EN defined, the counts SHALL increment on each matched resolve and on each mispredict respectively, saturate at 0xFFFF, and clear on reset.
REQ-035 Without LOOP_BRANCH_RESOLVER_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 A bench SHALL cover: push {0x11C, taken, 0x100}, then resolve {0x11C, taken, 0x100} -> no mispredict, pending 1->0, state IDLE.
REQ-037 A bench SHALL cover: push {0x11C, taken, 0x100}, then resolve {0x11C, not-taken} -> next cycle mispredict=1, correct_pc=0x120, pending=0, pred_ready=0 for 2 cycles.
REQ-038 A bench SHALL cover: push 4 entries (0x100, 0x104, 0x108, 0x10C) -> pred_ready=0; a 5th push is refused; a simultaneous resolve of 0x100 pops to 3 with the 5th still not accepted.
REQ-039 A bench SHALL cover: resolve 0x200 with an empty queue -> order_err pulse one cycle, pending stays 0, no mispredict.
REQ-040 A bench SHALL cover: mispredict on target (pred 0x100, actual 0x110) with a same-cycle push of 0x104 -> correct_pc=0x110, push dropped, pending=0.
REQ-041 A bench SHALL cover: reset asserted in the first RECOVER cycle -> IDLE next cycle, pred_ready=1, all outputs 0.
